// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the word-wide data memory.
// The arbiter uses the slave view; requesters and the memory together form the master view.
interface dmem_port_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [3:0]  a_be;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_ack;
    logic        a_err;
    logic [31:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [3:0]  b_be;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_ack;
    logic        b_err;
    logic [31:0] b_rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic        mem_write;
    logic [31:0] mem_out;
    logic        busy;

    modport slave (
        input  a_req, a_we, a_be, a_addr, a_wdata,
        input  b_req, b_we, b_be, b_addr, b_wdata,
        input  mem_out,
        output a_ack, a_err, a_rdata,
        output b_ack, b_err, b_rdata,
        output mem_addr, mem_in, mem_write, busy
    );

    modport master (
        output a_req, a_we, a_be, a_addr, a_wdata,
        output b_req, b_we, b_be, b_addr, b_wdata,
        output mem_out,
        input  a_ack, a_err, a_rdata,
        input  b_ack, b_err, b_rdata,
        input  mem_addr, mem_in, mem_write, busy
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter and byte-lane read-modify-write sequencer for the big-endian word memory.
// Build option DMEM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise port A has fixed priority.

module dmem_port_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic a_ack,
    input logic b_ack,
    input logic a_err,
    input logic b_err,
    input logic mem_write,
    input logic busy
);
    ack_exclusive: assert property (@(posedge clk) disable iff (!rst) !(a_ack && b_ack));
    a_err_with_ack: assert property (@(posedge clk) disable iff (!rst) a_err |-> a_ack);
    b_err_with_ack: assert property (@(posedge clk) disable iff (!rst) b_err |-> b_ack);
    write_while_busy: assert property (@(posedge clk) disable iff (!rst) mem_write |-> busy);
endmodule

module dmem_port_arbiter #(
    parameter int unsigned MEMORY_SIZE = 64
) (
    input logic                clk,
    input logic                rst,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2
    } state_t;

    localparam logic [31:0] LAST_LEGAL = 32'(MEMORY_SIZE - 32'd4);

    // Byte lane i of the word is written when be[i] is set; be[3] is the byte at addr+0.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (new_word & mask) | (old_word & ~mask);
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic        take_s;
    logic        done_s;
    logic        single_s;
    logic        grant_b_s;
    logic        sel_we_s;
    logic [3:0]  sel_be_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [31:0] rd_value_s;

    logic        port_b_r;
    logic        we_r;
    logic [3:0]  be_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        oor_r;
    logic [31:0] merge_r;

    logic        a_ack_r;
    logic        b_ack_r;
    logic        a_err_r;
    logic        b_err_r;
    logic [31:0] a_rdata_r;
    logic [31:0] b_rdata_r;

    logic [31:0] mem_addr_s;
    logic [31:0] mem_in_s;
    logic        mem_write_s;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_b_r;

    // Tie-break pointer: remembers the most recent winner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b_r <= 1'b1;
        end else if (take_s) begin
            last_b_r <= grant_b_s;
        end
    end

    // Round-robin grant: a tie goes to the port that did not win last.
    always_comb begin
        grant_b_s = 1'b0;
        if (bus.a_req && bus.b_req) begin
            grant_b_s = ~last_b_r;
        end else if (bus.b_req) begin
            grant_b_s = 1'b1;
        end else begin
            grant_b_s = 1'b0;
        end
    end
`else
    // Fixed-priority grant: port A wins every tie.
    always_comb begin
        grant_b_s = 1'b0;
        if (bus.a_req) begin
            grant_b_s = 1'b0;
        end else if (bus.b_req) begin
            grant_b_s = 1'b1;
        end else begin
            grant_b_s = 1'b0;
        end
    end
`endif

    // Request field mux for the winning port.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_be_s    = 4'h0;
        sel_addr_s  = 32'h0;
        sel_wdata_s = 32'h0;
        if (grant_b_s) begin
            sel_we_s    = bus.b_we;
            sel_be_s    = bus.b_be;
            sel_addr_s  = bus.b_addr;
            sel_wdata_s = bus.b_wdata;
        end else begin
            sel_we_s    = bus.a_we;
            sel_be_s    = bus.a_be;
            sel_addr_s  = bus.a_addr;
            sel_wdata_s = bus.a_wdata;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; anything that is not a partial in-range write finishes in ACCESS.
    always_comb begin
        state_s  = state_r;
        take_s   = 1'b0;
        done_s   = 1'b0;
        single_s = oor_r || !we_r || (be_r == 4'b1111) || (be_r == 4'b0000);
        case (state_r)
            ST_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    take_s  = 1'b1;
                    state_s = ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (single_s) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_MERGE;
                end
            end
            ST_MERGE: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Latch the granted request; the range check is resolved here for use in ACCESS.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_b_r <= 1'b0;
            we_r     <= 1'b0;
            be_r     <= 4'h0;
            addr_r   <= 32'h0;
            wdata_r  <= 32'h0;
            oor_r    <= 1'b0;
            merge_r  <= 32'h0;
        end else begin
            if (take_s) begin
                port_b_r <= grant_b_s;
                we_r     <= sel_we_s;
                be_r     <= sel_be_s;
                addr_r   <= sel_addr_s;
                wdata_r  <= sel_wdata_s;
                oor_r    <= (sel_addr_s > LAST_LEGAL);
            end
            if (state_r == ST_ACCESS) begin
                merge_r <= bus.mem_out;
            end
        end
    end

    assign rd_value_s = oor_r ? 32'h0 : bus.mem_out;

    // Completion flags and read data go only to the port that owns the access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_ack_r   <= 1'b0;
            b_ack_r   <= 1'b0;
            a_err_r   <= 1'b0;
            b_err_r   <= 1'b0;
            a_rdata_r <= 32'h0;
            b_rdata_r <= 32'h0;
        end else begin
            a_ack_r <= done_s && !port_b_r;
            b_ack_r <= done_s && port_b_r;
            a_err_r <= done_s && !port_b_r && oor_r;
            b_err_r <= done_s && port_b_r && oor_r;
            if (done_s && !port_b_r && !we_r) begin
                a_rdata_r <= rd_value_s;
            end
            if (done_s && port_b_r && !we_r) begin
                b_rdata_r <= rd_value_s;
            end
        end
    end

    // Memory port decode from registered state only, so an async reset kills a write at once.
    always_comb begin
        mem_addr_s  = 32'h0;
        mem_in_s    = 32'h0;
        mem_write_s = 1'b0;
        case (state_r)
            ST_ACCESS: begin
                mem_addr_s = addr_r;
                if (we_r && (be_r == 4'b1111) && !oor_r) begin
                    mem_write_s = 1'b1;
                    mem_in_s    = wdata_r;
                end else begin
                    mem_write_s = 1'b0;
                    mem_in_s    = 32'h0;
                end
            end
            ST_MERGE: begin
                mem_addr_s  = addr_r;
                mem_write_s = 1'b1;
                mem_in_s    = merge_bytes(merge_r, wdata_r, be_r);
            end
            default: begin
                mem_addr_s  = 32'h0;
                mem_in_s    = 32'h0;
                mem_write_s = 1'b0;
            end
        endcase
    end

    assign bus.a_ack     = a_ack_r;
    assign bus.b_ack     = b_ack_r;
    assign bus.a_err     = a_err_r;
    assign bus.b_err     = b_err_r;
    assign bus.a_rdata   = a_rdata_r;
    assign bus.b_rdata   = b_rdata_r;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_in    = mem_in_s;
    assign bus.mem_write = mem_write_s;
    assign bus.busy      = (state_r != ST_IDLE);

    dmem_port_arbiter_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .a_ack     (a_ack_r),
        .b_ack     (b_ack_r),
        .a_err     (a_err_r),
        .b_err     (b_err_r),
        .mem_write (mem_write_s),
        .busy      (state_r != ST_IDLE)
    );
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed plan items plus random traffic
// against a transaction-level model of memory contents, grant order and ack latency.
module tb_dmem_port_arbiter;
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    localparam int MEM_BYTES = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_cnt = 0;

    dmem_port_arbiter_if bus();

    dmem_port_arbiter #(.MEMORY_SIZE(MEM_BYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Attached memory (word-wide, combinational read, write at clock edge)
    logic [31:0] mem_arr [16] = '{default: 32'h0};
    assign bus.mem_out = mem_arr[bus.mem_addr[5:2]];
    always @(posedge clk) begin
        if (bus.mem_write === 1'b1) begin
            mem_arr[bus.mem_addr[5:2]] <= bus.mem_in;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [16] = '{default: 32'h0};
    logic [31:0] exp_rdata [2];
    bit          last_b;
    logic [31:0] tr_we   [0:31];
    logic [31:0] tr_addr [0:31];
    logic [31:0] tr_in   [0:31];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic bit out_of_range(input txn_t t);
        return t.addr > 32'(MEM_BYTES - 4);
    endfunction

    // Edges from acceptance to ack: partial in-range writes need the extra merge cycle
    function automatic int latency(input txn_t t);
        if (t.we && !out_of_range(t) && t.be != 4'hF && t.be != 4'h0) return 2;
        return 1;
    endfunction

    function automatic bit pick_b(input bit va, input bit vb);
        if (va && vb) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            return !last_b;
`else
            return 1'b0;
`endif
        end
        return vb && !va;
    endfunction

    task automatic model_apply(input int p, input txn_t t, output logic err);
        int w;
        err = out_of_range(t);
        w = int'(t.addr / 4);
        if (err) begin
            if (!t.we) exp_rdata[p] = 32'h0;
        end else if (!t.we) begin
            exp_rdata[p] = ref_mem[w];
        end else begin
            for (int i = 0; i < 4; i++)
                if (t.be[3-i]) ref_mem[w][31-8*i -: 8] = t.wdata[31-8*i -: 8];
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_a_ack"}, 32'(bus.a_ack), 32'h0);
        check_val({tag, "_b_ack"}, 32'(bus.b_ack), 32'h0);
        check_val({tag, "_a_err"}, 32'(bus.a_err), 32'h0);
        check_val({tag, "_b_err"}, 32'(bus.b_err), 32'h0);
        check_val({tag, "_a_rdata"}, bus.a_rdata, 32'h0);
        check_val({tag, "_b_rdata"}, bus.b_rdata, 32'h0);
        check_val({tag, "_mem_write"}, 32'(bus.mem_write), 32'h0);
        check_val({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        check_val({tag, "_mem_in"}, bus.mem_in, 32'h0);
        check_val({tag, "_busy"}, 32'(bus.busy), 32'h0);
    endtask

    // Issue one request per enabled port together; check ack timing, err and rdata
    task automatic run_txn(input bit va, input txn_t ta, input bit vb, input txn_t tb2);
        int ea, eb, kmax;
        bit first_b;
        logic e;
        ea = -1; eb = -1;
        bus.a_we = ta.we;  bus.a_be = ta.be;  bus.a_addr = ta.addr;  bus.a_wdata = ta.wdata;
        bus.b_we = tb2.we; bus.b_be = tb2.be; bus.b_addr = tb2.addr; bus.b_wdata = tb2.wdata;
        bus.a_req = va;
        bus.b_req = vb;
        first_b = pick_b(va, vb);
        last_b = first_b;
        if (va && vb) begin
            if (first_b) begin
                eb = 1 + latency(tb2);
                ea = eb + 1 + latency(ta);
            end else begin
                ea = 1 + latency(ta);
                eb = ea + 1 + latency(tb2);
            end
            last_b = !first_b;
        end else if (va) begin
            ea = 1 + latency(ta);
        end else begin
            eb = 1 + latency(tb2);
        end
        kmax = ((ea > eb) ? ea : eb) + 1;
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk); #1;
            tr_we[k]   = 32'(bus.mem_write);
            tr_addr[k] = bus.mem_addr;
            tr_in[k]   = bus.mem_in;
            check_val("a_ack", 32'(bus.a_ack), 32'(k == ea));
            check_val("b_ack", 32'(bus.b_ack), 32'(k == eb));
            if (k == ea) begin
                model_apply(0, ta, e);
                check_val("a_err", 32'(bus.a_err), 32'(e));
                check_val("a_rdata", bus.a_rdata, exp_rdata[0]);
                check_val("b_rdata_hold", bus.b_rdata, exp_rdata[1]);
                bus.a_req = 1'b0;
            end
            if (k == eb) begin
                model_apply(1, tb2, e);
                check_val("b_err", 32'(bus.b_err), 32'(e));
                check_val("b_rdata", bus.b_rdata, exp_rdata[1]);
                check_val("a_rdata_hold", bus.a_rdata, exp_rdata[0]);
                bus.b_req = 1'b0;
            end
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int sel;
        t.we = 1'($urandom_range(0, 1));
        sel = int'($urandom_range(0, 3));
        t.be = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 8) t.addr = 32'($urandom_range(0, 15) * 4);
        else t.addr = 32'($urandom_range(61, 80));
        t.wdata = $urandom;
        return t;
    endfunction

    initial begin
        txn_t idle_t, ta, tb2;
        int wr0, cnt, got;
        bit exp_seq [4];
        logic e;
        idle_t = mk(1'b0, 4'h0, 32'h0, 32'h0);
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        bus.a_we = 1'b0; bus.a_be = 4'h0; bus.a_addr = 32'h0; bus.a_wdata = 32'h0;
        bus.b_we = 1'b0; bus.b_be = 4'h0; bus.b_addr = 32'h0; bus.b_wdata = 32'h0;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        last_b = 1'b1;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.a_req = 1'($urandom); bus.b_req = 1'($urandom);
            bus.a_we = 1'($urandom);  bus.b_we = 1'($urandom);
            bus.a_be = 4'($urandom);  bus.b_be = 4'($urandom);
            bus.a_addr = $urandom;    bus.b_addr = $urandom;
            bus.a_wdata = $urandom;   bus.b_wdata = $urandom;
            check_idle_outputs("reset");
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        // Full-word write then read on port A
        wr0 = wr_cnt;
        run_txn(1'b1, mk(1'b1, 4'hF, 32'd8, 32'h11223344), 1'b0, idle_t);
        check_val("fullwr_count", 32'(wr_cnt - wr0), 32'd1);
        check_val("fullwr_we", tr_we[1], 32'd1);
        check_val("fullwr_addr", tr_addr[1], 32'd8);
        run_txn(1'b1, mk(1'b0, 4'hF, 32'd8, 32'h0), 1'b0, idle_t);
        check_val("rd_full", bus.a_rdata, 32'h11223344);

        // Partial write goes through MERGE
        run_txn(1'b1, mk(1'b1, 4'b0100, 32'd8, 32'h00AA0000), 1'b0, idle_t);
        check_val("merge_we", tr_we[2], 32'd1);
        check_val("merge_in", tr_in[2], 32'h11AA3344);
        run_txn(1'b1, mk(1'b0, 4'hF, 32'd8, 32'h0), 1'b0, idle_t);
        check_val("rd_merged", bus.a_rdata, 32'h11AA3344);

        // Out of range read and write
        wr0 = wr_cnt;
        run_txn(1'b1, mk(1'b0, 4'hF, 32'd61, 32'h0), 1'b0, idle_t);
        check_val("oor_rdata", bus.a_rdata, 32'h0);
        run_txn(1'b1, mk(1'b1, 4'hF, 32'd64, 32'hDEADBEEF), 1'b0, idle_t);
        check_val("oor_no_write", 32'(wr_cnt - wr0), 32'd0);

        // Contention with both requests held high
        ta = mk(1'b0, 4'hF, 32'd0, 32'h0);
        tb2 = mk(1'b0, 4'hF, 32'd4, 32'h0);
        for (int i = 0; i < 4; i++) begin
            exp_seq[i] = pick_b(1'b1, 1'b1);
            last_b = exp_seq[i];
        end
        bus.a_we = ta.we;  bus.a_be = ta.be;  bus.a_addr = ta.addr;  bus.a_wdata = ta.wdata;
        bus.b_we = tb2.we; bus.b_be = tb2.be; bus.b_addr = tb2.addr; bus.b_wdata = tb2.wdata;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 4; c++) begin
            @(posedge clk); #1;
            if (bus.a_ack || bus.b_ack) begin
                check_val("ack_onehot", 32'(bus.a_ack && bus.b_ack), 32'h0);
                got = bus.b_ack ? 1 : 0;
                check_val("grant_order", 32'(got), 32'(exp_seq[cnt]));
                model_apply(got, got ? tb2 : ta, e);
                check_val("cont_a_rdata", bus.a_rdata, exp_rdata[0]);
                check_val("cont_b_rdata", bus.b_rdata, exp_rdata[1]);
                cnt++;
                if (cnt == 4) begin
                    bus.a_req = 1'b0; bus.b_req = 1'b0;
                end
            end
        end
        check_val("contention_acks", 32'(cnt), 32'd4);
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        @(posedge clk); #1;

        // Reset in the MERGE cycle of a partial write
        run_txn(1'b1, mk(1'b1, 4'hF, 32'd12, 32'hCAFEBABE), 1'b0, idle_t);
        bus.a_we = 1'b1; bus.a_be = 4'b0011; bus.a_addr = 32'd12; bus.a_wdata = 32'h00001234;
        bus.a_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("pre_rst_merge_we", 32'(bus.mem_write), 32'd1);
        rst = 1'b0;
        #1;
        check_val("rst_drops_we", 32'(bus.mem_write), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        bus.a_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_val("rst_no_ack", 32'(bus.a_ack), 32'd0);
        end
        @(negedge clk) rst = 1'b1;
        exp_rdata[0] = 32'h0; exp_rdata[1] = 32'h0;
        last_b = 1'b1;
        @(posedge clk); #1;
        check_val("rst_no_ack_after", 32'(bus.a_ack), 32'd0);
        check_val("rst_word_kept", mem_arr[3], 32'hCAFEBABE);
        run_txn(1'b1, mk(1'b0, 4'hF, 32'd12, 32'h0), 1'b0, idle_t);
        check_val("rst_readback", bus.a_rdata, 32'hCAFEBABE);

        // Random traffic on one or both ports
        for (int i = 0; i < 60; i++) begin
            bit va, vb;
            va = 1'($urandom_range(0, 1));
            vb = 1'($urandom_range(0, 1));
            if (!va && !vb) va = 1'b1;
            run_txn(va, rand_txn(), vb, rand_txn());
        end

        for (int i = 0; i < 16; i++) check_val("mem_word", mem_arr[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter and byte-lane write sequencer in front of the word-wide, big-endian data memory. Port A is the CPU load/store stage; port B is the loader/debug port. The block serialises their accesses onto the single memory port. It turns partial (byte-enable) writes into a read-modify-write pair, because the memory only supports full-word writes. It also flags accesses outside the memory window.

## Interface
Parameters:
- MEMORY_SIZE, 64: size of the attached memory in bytes; a word access at addr is legal when addr <= MEMORY_SIZE-4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- a_req / b_req  in  1  access request; hold stable with all fields until ack
- a_we / b_we  in  1  1 = write, 0 = read
- a_be / b_be  in  4  write byte enables; be[3] = wdata[31:24] = byte at addr+0, be[0] = wdata[7:0] = byte at addr+3
- a_addr / b_addr  in  32  byte address
- a_wdata / b_wdata  in  32  write data
- a_ack / b_ack  out  1  one-cycle completion pulse
- a_err / b_err  out  1  valid with ack; address out of range
- a_rdata / b_rdata  out  32  read data, updated on that port's read ack
- mem_addr  out  32  memory address
- mem_in  out  32  memory write data
- mem_write  out  1  memory write strobe
- mem_out  in  32  combinational memory read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCESS, MERGE.
- IDLE: if any req, pick a winner and latch its we/be/addr/wdata plus the port id. Then go to ACCESS. Otherwise stay.
- ACCESS, read: capture mem_out as the read data; go to IDLE with ack.
- ACCESS, write with be=4'b1111: mem_write=1, mem_in=wdata; go to IDLE with ack.
- ACCESS, write with be=4'b0000: no mem_write; go to IDLE with ack.
- ACCESS, other writes: capture mem_out into the merge register; go to MERGE.
- MERGE: mem_write=1. mem_in takes wdata bytes where be=1 and merge-register bytes elsewhere. Go to IDLE with ack.
- Out of range (addr > MEMORY_SIZE-4): checked in ACCESS.
  - mem_write stays 0 and MERGE is skipped.
  - Ack is given with err=1.
  - For a read, rdata is set to 0.
- mem_addr, mem_in and mem_write are decoded from registered state only. In IDLE: mem_write=0, mem_addr=0, mem_in=0.
- Ack goes only to the latched port. rdata of the other port is unchanged. Writes leave rdata unchanged.
- Requester rule: drop req in the ack cycle. A req still high in the ack cycle is taken as a new request.

## Timing
- Reset values: state IDLE, all ack/err 0, a_rdata = b_rdata = 0, mem_write 0, busy 0, arbitration pointer = "last granted B".
- Reset is asynchronous. Asserting it mid-operation drops mem_write immediately. The pending ack is lost and no partial write is completed.
- Edge numbering: req is sampled at edge e0, which enters ACCESS.
  - Read, full write, be=0 and error accesses: ack is high for one cycle after e1.
  - Partial write: MERGE after e1, ack after e2.
- Back-to-back: a new req may be sampled in the ack cycle (state is IDLE). This gives a throughput of one access per 2 cycles, or per 3 cycles for partial writes.
- The memory write commits at the edge that ends the ACCESS or MERGE cycle.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined: when both ports request in IDLE, grant goes to the port not granted last. The pointer updates on each grant. A single requester always wins.
- Not defined: fixed priority; port A always wins a simultaneous request. The pointer register is not built.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs.
  - Required: every output is 0, busy=0, no mem_write.
- Port A full-word write then read: write addr=8, wdata=0x11223344, be=4'hF. Then read addr=8.
  - Write: mem_write pulses once, with mem_addr=8.
  - Read: a_ack comes 2 cycles after req, with a_rdata=0x11223344 and a_err=0.
- Partial write: word 8 holds 0x11223344. Write addr=8, be=4'b0100, wdata=0x00AA0000.
  - MERGE cycle shows mem_in=0x11AA3344.
  - a_ack comes 3 cycles after req.
  - Readback gives 0x11AA3344.
- Contention: a_req and b_req held high continuously, each port re-requesting after ack.
  - With DMEM_ARB_ROUND_ROBIN_EN: grants go A, B, A, B.
  - Without: A every time, and b_ack never arrives.
- Out of range: read addr=61 and write addr=64.
  - Both ack with err=1.
  - mem_write never asserts, and the read returns a_rdata=0.
- Reset mid-operation: pull rst low in the MERGE cycle of a partial write.
  - mem_write drops in the same cycle and no ack is issued.
  - After release, a read of the target word shows it unchanged.
